// File: rtl/seq_gen_010.sv
// Serial "010" pattern transmitter: shifts parallel frames out MSB-first on a line
// that idles high, and runs a golden copy of the detector FSM on its own output.
module seq_gen_010 #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done,
    output logic             hit,
    output logic [CNT_W-1:0] exp_count
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic {
        TX_IDLE,
        TX_SHIFT
    } tx_state_t;

    typedef enum logic [1:0] {
        M_IDLE,
        M_ZERO,
        M_ONE,
        M_STORE
    } m_state_t;

    tx_state_t        state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    m_state_t         m_q, m_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic last_bit;
    logic accept;

    assign last_bit = (state_q == TX_SHIFT) && (idx_q == LAST_IDX);
    assign accept   = din_valid && din_ready;

    // State register; the shift register is pure data and carries no reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= TX_IDLE;
            idx_q   <= '0;
            m_q     <= M_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
        end
        sreg_q <= sreg_d;
    end

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        idx_d   = idx_q;
        case (state_q)
            TX_IDLE: begin
                if (accept) begin
                    state_d = TX_SHIFT;
                    sreg_d  = din;
                    idx_d   = '0;
                end
            end
            TX_SHIFT: begin
                if (idx_q == LAST_IDX) begin
                    if (accept) begin
                        sreg_d = din;
                        idx_d  = '0;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end else begin
                    sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
                    idx_d  = idx_q + 1'b1;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // Golden detector: non-overlapping, STORE always falls back to IDLE or ZERO.
    always_comb begin
        m_d = m_q;
        case (m_q)
            M_IDLE:  m_d = x ? M_IDLE : M_ZERO;
            M_ZERO:  m_d = x ? M_ONE  : M_ZERO;
            M_ONE:   m_d = x ? M_IDLE : M_STORE;
            M_STORE: m_d = x ? M_IDLE : M_ZERO;
            default: m_d = M_IDLE;
        endcase
        cnt_d = (m_q == M_STORE) ? cnt_q + 1'b1 : cnt_q;
    end

    always_comb begin
        x         = (state_q == TX_SHIFT) ? sreg_q[WIDTH-1] : 1'b1;
        x_valid   = (state_q == TX_SHIFT);
        busy      = (state_q == TX_SHIFT);
        done      = last_bit;
        din_ready = (state_q == TX_IDLE) || last_bit;
        hit       = (m_q == M_STORE);
        exp_count = cnt_q;
    end

endmodule

// File: tb/tb_seq_gen_010.sv
// Bench for seq_gen_010: frame table plus hand-written multi-cycle sequences,
// serial bits scored against a queue filled at each accepted handshake.
module tb_seq_gen_010;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready, x, x_valid, busy, done, hit;
    logic [9:0] exp_count;

    logic [7:0] din2;
    logic       dv2;
    logic       din_ready2, x2, x_valid2, busy2, done2, hit2;
    logic [1:0] exp_count2;

    always #5 clk = ~clk;

    seq_gen_010 #(.WIDTH(8), .CNT_W(10)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .x(x), .x_valid(x_valid), .busy(busy),
        .done(done), .hit(hit), .exp_count(exp_count)
    );

    seq_gen_010 #(.WIDTH(8), .CNT_W(2)) dut_wrap (
        .clk(clk), .rst(rst), .din(din2), .din_valid(dv2),
        .din_ready(din_ready2), .x(x2), .x_valid(x_valid2), .busy(busy2),
        .done(done2), .hit(hit2), .exp_count(exp_count2)
    );

    typedef struct packed {
        logic b;
        logic last;
    } sb_t;

    typedef struct {
        logic [7:0] din;
        int         det;
    } vec_t;

    sb_t  sb_q[$];
    vec_t vecs[10];
    int   checks = 0;
    int   errors = 0;
    int   hits   = 0;
    int   hits2  = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // One clock: records any handshake into the scoreboard, then scores outputs.
    task automatic tick();
        logic       acc;
        logic [7:0] f;
        sb_t        e;
        acc = din_valid && din_ready && !rst;
        f   = din;
        @(posedge clk);
        if (acc) begin
            for (int k = 7; k >= 0; k--) begin
                e.b    = f[k];
                e.last = (k == 0);
                sb_q.push_back(e);
            end
        end
        #1;
        hits  += int'(hit);
        hits2 += int'(hit2);
        if (x_valid) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_bit", int'(x_valid), 0);
            end else begin
                e = sb_q.pop_front();
                check("sb_x", int'(x), int'(e.b));
                check("sb_done", int'(done), int'(e.last));
            end
        end else begin
            check("idle_x", int'(x), 1);
            check("idle_done", int'(done), 0);
            if (sb_q.size() != 0) check("sb_stall", int'(x_valid), 1);
        end
        check("busy_eq_valid", int'(busy), int'(x_valid));
        check("wrap_busy_eq_valid", int'(busy2), int'(x_valid2));
        if (!x_valid2) check("wrap_idle_x", int'(x2), 1);
        if (done2) check("wrap_done_valid", int'(x_valid2), 1);
    endtask

    task automatic send(input logic [7:0] f, input bit keep, output int waited);
        din       = f;
        din_valid = 1'b1;
        waited    = 0;
        while (!din_ready && waited < 40) begin
            tick();
            waited++;
        end
        if (!din_ready) check("send_timeout", int'(din_ready), 1);
        else tick();
        if (!keep) din_valid = 1'b0;
    endtask

    initial begin
        int         w;
        int         h0;
        logic [9:0] c0;
        logic [9:0] diff;

        vecs[0] = '{8'h4A, 2};
        vecs[1] = '{8'h49, 2};
        vecs[2] = '{8'h00, 0};
        vecs[3] = '{8'hFF, 0};
        vecs[4] = '{8'h55, 2};
        vecs[5] = '{8'hAA, 2};
        vecs[6] = '{8'h0A, 1};
        vecs[7] = '{8'h02, 1};
        vecs[8] = '{8'h24, 2};
        vecs[9] = '{8'hA5, 2};

        rst = 1'b1; din = '0; din_valid = 1'b0; din2 = '0; dv2 = 1'b0;
        tick();
        tick();
        check("rst_x", int'(x), 1);
        check("rst_x_valid", int'(x_valid), 0);
        check("rst_din_ready", int'(din_ready), 1);
        check("rst_hit", int'(hit), 0);
        check("rst_exp_count", int'(exp_count), 0);
        check("rst_wrap_count", int'(exp_count2), 0);
        rst = 1'b0;
        repeat (3) tick();

        for (int i = 0; i < 10; i++) begin
            c0 = exp_count;
            h0 = hits;
            send(vecs[i].din, 1'b0, w);
            check("vec_wait", w, 0);
            repeat (12) tick();
            diff = exp_count - c0;
            check($sformatf("vec%0d_hits", i), hits - h0, vecs[i].det);
            check($sformatf("vec%0d_count", i), int'(diff), vecs[i].det);
        end

        c0 = exp_count;
        send(8'h55, 1'b1, w);
        check("b2b_first_ready_low", int'(din_ready), 0);
        send(8'hAA, 1'b0, w);
        check("b2b_ready_wait", w, 7);
        repeat (12) tick();
        diff = exp_count - c0;
        check("b2b_count", int'(diff), 4);

        send(8'h4A, 1'b0, w);
        tick();
        tick();
        sb_q.delete();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_x", int'(x), 1);
        check("abort_x_valid", int'(x_valid), 0);
        check("abort_count", int'(exp_count), 0);
        check("abort_hit", int'(hit), 0);
        check("abort_ready", int'(din_ready), 1);
        send(8'hA5, 1'b0, w);
        check("after_abort_wait", w, 0);
        repeat (12) tick();
        check("after_abort_count", int'(exp_count), 2);

        c0 = exp_count;
        send(8'h00, 1'b0, w);
        repeat (3) tick();
        din = 8'hFF;
        din_valid = 1'b1;
        check("offer_ready_low", int'(din_ready), 0);
        send(8'hFF, 1'b0, w);
        check("offer_wait", w, 4);
        repeat (12) tick();
        diff = exp_count - c0;
        check("offer_count", int'(diff), 0);

        check("wrap_ready", int'(din_ready2), 1);
        din2 = 8'h49; dv2 = 1'b1;
        tick();
        dv2 = 1'b0;
        repeat (12) tick();
        check("wrap_count_mid", int'(exp_count2), 2);
        din2 = 8'h49; dv2 = 1'b1;
        tick();
        dv2 = 1'b0;
        repeat (12) tick();
        check("wrap_count_end", int'(exp_count2), 0);
        check("wrap_hits", hits2, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_gen_010.md
# seq_gen_010

Serial pattern transmitter that drives the single-bit stream consumed by the team's "010" sequence detectors. It accepts parallel frames over a valid/ready handshake and shifts them out MSB-first, one bit per clock. The line idles high between frames. It also runs a golden copy of the detector state machine on its own output. `hit` and `exp_count` therefore track, cycle for cycle, what a downstream detector on the same clock must report, so the block doubles as a self-checking stimulus source.

## Interface
- `WIDTH`, default 8: frame width in bits (at least 2).
- `CNT_W`, default 10: width of `exp_count`.
- `clk`  input  1: single clock, rising edge.
- `rst`  input  1: reset, synchronous, active-high.
- `din`  input  WIDTH: frame to transmit. Sampled on the handshake edge.
- `din_valid`  input  1: `din` holds a frame.
- `din_ready`  output  1: block can accept a frame this cycle.
- `x`  output  1: serial line, registered. Idles at 1.
- `x_valid`  output  1: `x` carries a frame bit this cycle.
- `busy`  output  1: frame in progress (same as `x_valid`).
- `done`  output  1: one-cycle pulse while the last frame bit is on `x`.
- `hit`  output  1: golden detector output, high while the model is in STORE.
- `exp_count`  output  CNT_W: golden count of "010" detections.

## Operation
- Transmit FSM states:
  - TX_IDLE: `x`=1, `x_valid`=0, `din_ready`=1.
  - TX_SHIFT: holds a WIDTH-bit shift register and a bit index 0..WIDTH-1.
- Handshake: a frame is accepted on any edge where `din_valid && din_ready`. `din` is loaded into the shift register and the index is cleared.
- TX_SHIFT behaviour:
  - `x` = shift register MSB. The register shifts left one bit per edge.
  - `din_ready`=1 only on the last bit (index WIDTH-1), so frames can run back-to-back with no gap.
- On the last bit, the next state depends on whether a frame is accepted on that edge:
  - Frame accepted: reload the shift register and stay in TX_SHIFT.
  - No frame: go to TX_IDLE, so `x` returns to 1 on the next cycle.
- `din_valid` while `din_ready`=0 is ignored. The upstream must hold `din` stable.
- Golden model: a 2-bit state `m` advances on every edge, including idle cycles, using the value `x` held during the preceding cycle.
  - IDLE: 1→IDLE, 0→ZERO.
  - ZERO: 1→ONE, 0→ZERO.
  - ONE: 1→IDLE, 0→STORE.
  - STORE: 1→IDLE, 0→ZERO.
- `hit` = (`m`==STORE), combinational from `m`.
- `exp_count` increments on every edge where `m`==STORE and wraps modulo 2^CNT_W.
- Overlap rule: detections do not overlap. For example, 01010 yields one detection; 010010 yields two.

## Timing
- State after any reset edge:
  - TX_IDLE.
  - `x`=1, `x_valid`=0, `busy`=0, `done`=0.
  - `m`=IDLE, `hit`=0, `exp_count`=0, `din_ready`=1.
- Latency: for a frame accepted on edge E, bit k (MSB = bit 0) appears on `x` in the cycle after edge E+k. `done` is high in the cycle after edge E+WIDTH-1.
- Detection timing for a "010" whose final 0 is on `x` during cycle C:
  - `hit` is high in cycle C+1.
  - `exp_count` shows the increment from cycle C+2.
- Reset mid-frame: the frame is aborted. No further frame bits are sent; `x`=1 from the cycle after the reset edge. Model and count are cleared.
- Reset has priority over a simultaneous handshake: the offered frame is not accepted.
- Throughput: one WIDTH-bit frame every WIDTH cycles when `din_valid` is held high.

## Test plan
- Reset: hold `rst` for 2 edges, then release. Required: `x`=1, `x_valid`=0, `din_ready`=1, `hit`=0, `exp_count`=0.
- Single frame 8'h4A (01001010), accepted at edge E, line idle before.
  - `x` = 0,1,0,0,1,0,1,0 in the cycles after E..E+7.
  - `done` high only after E+7; `x` returns to 1 afterwards.
  - `hit` pulses twice; `exp_count`=2.
- Back-to-back 8'h55 then 8'hAA with `din_valid` held high.
  - 16 consecutive frame bits with no idle cycle.
  - `din_ready` high only on bit 7 of the first frame.
  - `exp_count`=4.
- Reset on the edge after bit 2 of frame 8'h4A.
  - Required: `x`=1, `x_valid`=0, `exp_count`=0 on the next cycle.
  - A new frame is accepted normally afterwards.
- Offer 8'hFF while frame 8'h00 is at bit 3.
  - Required: not accepted until bit 7. 8'hFF then follows immediately.
  - `exp_count` unchanged (0 for 8'h00 followed by 8'hFF).
- Wrap: with CNT_W=2, send 8'h49 twice with idle gaps (2 detections each). Required: `exp_count` ends at 0.
